axi_wr_burst_master: RTL and testbench
======================================

// Module: axi_wr_burst_master
// PURPOSE
//  AXI4 write-burst master on ddr_clk that drains the write-side FIFO (256-bit, first-word-fall-through read port) into DDR.
//  - Starts a fixed-length INCR burst once the FIFO read water level covers one burst.
//  - Requests the DDR port from the axi_ctrl_arbitration arbiter before each burst.
//  - Walks a single frame buffer linearly, wraps at frame end, and restarts on a frame-start pulse.
// PARAMETERS
//  AXI_ADDR_W   32            AXI address width
//  BURST_LEN    16            beats per burst (1..256); awlen = BURST_LEN-1
//  FRAME_BASE   32'h0000_0000 byte address of frame buffer start (must be 4 KB aligned)
//  FRAME_BYTES  32'h007E_9000 frame size in bytes (1920x1080x4); must be a multiple of BURST_LEN*32
// PORTS
//  ddr_clk               in   1    single clock (DDR AXI4 clock)
//  rstn                  in   1    asynchronous active-low reset
//  frame_start           in   1    1-cycle pulse, ddr_clk domain: restart at FRAME_BASE
//  wfifo_rd_water_level  in   9    256-bit words available in FIFO
//  wfifo_rd_data256_out  in   256  FIFO head word (FWFT, valid while level>0)
//  wfifo_rd_req          out  1    FIFO pop, one word per cycle high
//  arb_req               out  1    request for DDR write port
//  arb_grant             in   1    arbiter grant, level
//  arb_done              out  1    1-cycle pulse: burst finished, port released
//  m_axi_awaddr          out  AXI_ADDR_W  burst address
//  m_axi_awlen           out  8    BURST_LEN-1 (constant)
//  m_axi_awsize          out  3    3'b101, 32 bytes (constant)
//  m_axi_awburst         out  2    2'b01, INCR (constant)
//  m_axi_awvalid         out  1    address valid
//  m_axi_awready         in   1    address ready
//  m_axi_wdata           out  256  = wfifo_rd_data256_out
//  m_axi_wstrb           out  32   all ones (constant)
//  m_axi_wlast           out  1    last beat of burst
//  m_axi_wvalid          out  1    data valid
//  m_axi_wready          in   1    data ready
//  m_axi_bresp           in   2    write response
//  m_axi_bvalid          in   1    response valid
//  m_axi_bready          out  1    response ready
//  wr_err                out  1    sticky: any BRESP != OKAY since reset
//  frame_done            out  1    1-cycle pulse: last burst of frame acknowledged
// BEHAVIOUR
//  Reset values
//  - All valid/req/pulse outputs are 0; wr_err is 0.
//  - Internal address is FRAME_BASE; beat counter is 0; state is IDLE.
//  FSM
//  - IDLE -> REQ when wfifo_rd_water_level >= BURST_LEN.
//  - REQ: arb_req=1. -> AW on arb_grant. arb_req stays 1 through AW/W/B.
//  - AW: awvalid=1 with the registered awaddr. -> W on awvalid & awready.
//  - W: wvalid=1; wfifo_rd_req = wvalid & wready.
//    - Beat counter counts accepted beats.
//    - wlast=1 when count == BURST_LEN-1. -> B on the last accepted beat.
//  - B: bready=1. On bvalid: arb_done=1 for 1 cycle, arb_req drops in the same cycle, address advances, -> IDLE.
//  Timing and handshakes
//  - Min 1 idle cycle between bursts (IDLE re-evaluates level after B).
//  - AXI valids never drop before their ready; awaddr and wlast stay stable while stalled.
//  - wvalid is never asserted before the AW handshake.
//  Address
//  - next = addr + BURST_LEN*32.
//  - If next == FRAME_BASE+FRAME_BYTES: next = FRAME_BASE and frame_done pulses with the B handshake.
//  Frame start
//  - frame_start in IDLE/REQ: address <= FRAME_BASE immediately.
//  - frame_start in AW/W/B: latched as pending; the burst completes; the address is loaded from FRAME_BASE at the B handshake. Pending overrides the wrap and frame_done.
//  Errors and reset
//  - bresp != 2'b00 at the B handshake sets wr_err. The address still advances; no retry.
//  - rstn low mid-burst aborts immediately to reset values. The FIFO is reset by its owner on the same rstn.
// TESTING
//  1) level=15, grant=1 -> no arb_req; level=16 -> arb_req, AW at FRAME_BASE, awlen=15, 16 beats with wlast on beat 16, arb_done after bvalid.
//  2) wready toggling 1-0-1 for the whole burst -> exactly 16 pops; wdata matches FIFO order; wlast stable while stalled.
//  3) FRAME_BYTES=1024, back-to-back bursts -> awaddr 0x000, 0x200, 0x000; frame_done pulses on 2nd B.
//  4) frame_start during W of burst at 0x200 -> burst completes; next awaddr = FRAME_BASE; no frame_done.
//  5) bresp=2'b10 on a burst -> wr_err=1 and stays 1; next awaddr still +512.
//  6) rstn low during W beat 5 -> all outputs 0 asynchronously; after release the first awaddr is FRAME_BASE.

Source files
------------

// File: rtl/axi_wr_burst_master.sv
// AXI4 write-burst master: drains a 256-bit FWFT FIFO into a linear frame
// buffer using fixed-length INCR bursts, arbitrating for the DDR write port
// before each burst.
module axi_wr_burst_master #(
  parameter int unsigned           AXI_ADDR_W  = 32,
  parameter int unsigned           BURST_LEN   = 16,
  parameter logic [AXI_ADDR_W-1:0] FRAME_BASE  = '0,
  parameter logic [AXI_ADDR_W-1:0] FRAME_BYTES = AXI_ADDR_W'(32'h007E_9000)
) (
  input  logic                  ddr_clk,
  input  logic                  rstn,
  input  logic                  frame_start,
  input  logic [8:0]            wfifo_rd_water_level,
  input  logic [255:0]          wfifo_rd_data256_out,
  output logic                  wfifo_rd_req,
  output logic                  arb_req,
  input  logic                  arb_grant,
  output logic                  arb_done,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [255:0]          m_axi_wdata,
  output logic [31:0]           m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  wr_err,
  output logic                  frame_done
);

  localparam logic [AXI_ADDR_W-1:0] BURST_BYTES = AXI_ADDR_W'(BURST_LEN * 32);
  localparam logic [AXI_ADDR_W-1:0] FRAME_END   = FRAME_BASE + FRAME_BYTES;
  localparam logic [8:0]            LEVEL_NEED  = 9'(BURST_LEN);
  localparam logic [7:0]            LAST_IDX    = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_AW, S_W, S_B} state_t;

  state_t                  state;
  logic [AXI_ADDR_W-1:0]   addr;
  logic [AXI_ADDR_W-1:0]   next_addr;
  logic [7:0]              beat_cnt;
  logic                    fs_pending;

  // Constant burst attributes and FIFO pass-through
  assign m_axi_awlen   = LAST_IDX;
  assign m_axi_awsize  = 3'b101;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = wfifo_rd_data256_out;
  assign m_axi_awaddr  = addr;
  assign wfifo_rd_req  = m_axi_wvalid & m_axi_wready;
  assign next_addr     = addr + BURST_BYTES;

  // Burst sequencing FSM with registered handshake outputs and address walk
  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      addr          <= FRAME_BASE;
      beat_cnt      <= '0;
      fs_pending    <= 1'b0;
      arb_req       <= 1'b0;
      arb_done      <= 1'b0;
      frame_done    <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      arb_done   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) addr <= FRAME_BASE;
          if (wfifo_rd_water_level >= LEVEL_NEED) begin
            arb_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (frame_start) addr <= FRAME_BASE;
          if (arb_grant) begin
            m_axi_awvalid <= 1'b1;
            state         <= S_AW;
          end
        end
        S_AW: begin
          if (frame_start) fs_pending <= 1'b1;
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wlast   <= (LAST_IDX == '0);
            beat_cnt      <= '0;
            state         <= S_W;
          end
        end
        S_W: begin
          if (frame_start) fs_pending <= 1'b1;
          if (m_axi_wready) begin
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_bready <= 1'b1;
              state        <= S_B;
            end else begin
              // wlast is registered, so it is set one beat ahead from the incremented count
              beat_cnt    <= beat_cnt + 8'd1;
              m_axi_wlast <= ((beat_cnt + 8'd1) == LAST_IDX);
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            arb_req      <= 1'b0;
            arb_done     <= 1'b1;
            fs_pending   <= 1'b0;
            state        <= S_IDLE;
            if (m_axi_bresp != 2'b00) wr_err <= 1'b1;
            // a frame restart seen during the burst wins over the natural wrap
            if (fs_pending || frame_start) begin
              addr <= FRAME_BASE;
            end else if (next_addr == FRAME_END) begin
              addr       <= FRAME_BASE;
              frame_done <= 1'b1;
            end else begin
              addr <= next_addr;
            end
          end else if (frame_start) begin
            fs_pending <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Self-checking bench for axi_wr_burst_master: threshold table plus
// hand-written burst sequences (stalls, wrap, frame restart, error, abort).
module tb_axi_wr_burst_master;

  localparam int unsigned BL     = 16;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] FBYTES = 32'd1024;
  localparam logic [31:0] BBYTES = 32'd512;

  logic          ddr_clk = 1'b0;
  logic          rstn;
  logic          frame_start;
  logic [8:0]    wfifo_rd_water_level;
  logic [255:0]  wfifo_rd_data256_out;
  logic          wfifo_rd_req;
  logic          arb_req;
  logic          arb_grant;
  logic          arb_done;
  logic [31:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [255:0]  m_axi_wdata;
  logic [31:0]   m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic          wr_err;
  logic          frame_done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned wr_idx;
  int unsigned rd_idx;
  int unsigned exp_idx;
  logic        err_exp;

  axi_wr_burst_master #(
    .AXI_ADDR_W (32),
    .BURST_LEN  (BL),
    .FRAME_BASE (BASE),
    .FRAME_BYTES(FBYTES)
  ) dut (
    .ddr_clk              (ddr_clk),
    .rstn                 (rstn),
    .frame_start          (frame_start),
    .wfifo_rd_water_level (wfifo_rd_water_level),
    .wfifo_rd_data256_out (wfifo_rd_data256_out),
    .wfifo_rd_req         (wfifo_rd_req),
    .arb_req              (arb_req),
    .arb_grant            (arb_grant),
    .arb_done             (arb_done),
    .m_axi_awaddr         (m_axi_awaddr),
    .m_axi_awlen          (m_axi_awlen),
    .m_axi_awsize         (m_axi_awsize),
    .m_axi_awburst        (m_axi_awburst),
    .m_axi_awvalid        (m_axi_awvalid),
    .m_axi_awready        (m_axi_awready),
    .m_axi_wdata          (m_axi_wdata),
    .m_axi_wstrb          (m_axi_wstrb),
    .m_axi_wlast          (m_axi_wlast),
    .m_axi_wvalid         (m_axi_wvalid),
    .m_axi_wready         (m_axi_wready),
    .m_axi_bresp          (m_axi_bresp),
    .m_axi_bvalid         (m_axi_bvalid),
    .m_axi_bready         (m_axi_bready),
    .wr_err               (wr_err),
    .frame_done           (frame_done)
  );

  always #5 ddr_clk = ~ddr_clk;

  // Word i of the FIFO stream: distinct per index and per 32-bit lane
  function automatic logic [255:0] word(input int unsigned i);
    logic [255:0] r;
    for (int unsigned k = 0; k < 8; k++)
      r[k*32 +: 32] = 32'hD000_0000 + (i << 4) + k;
    return r;
  endfunction

  // FWFT FIFO model: writer index advanced by the stimulus, reader by pops
  always @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) rd_idx <= 0;
    else if (wfifo_rd_req) rd_idx <= rd_idx + 1;
  end
  assign wfifo_rd_water_level = ((wr_idx - rd_idx) > 511) ? 9'd511 : 9'(wr_idx - rd_idx);
  assign wfifo_rd_data256_out = word(rd_idx);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    frame_start   = 1'b0;
    arb_grant     = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    wr_idx        = 0;
    exp_idx       = 0;
    err_exp       = 1'b0;
    repeat (2) @(posedge ddr_clk);
    #1 rstn = 1'b1;
  endtask

  // One full burst: AW stall, W beats (optionally wready 1-0-1), B handshake
  task automatic burst(input logic [31:0] exp_addr, input logic [1:0] resp,
                       input bit toggle_w, input bit exp_fdone, input bit fs_mid);
    int unsigned n;
    int unsigned beats;
    wr_idx    = wr_idx + BL;
    arb_grant = 1'b1;
    n = 0;
    while (!m_axi_awvalid && n < 50) begin
      cycle();
      n++;
    end
    chk("aw_seen", m_axi_awvalid, 1'b1);
    chk("awaddr", m_axi_awaddr, exp_addr);
    chk("awlen", m_axi_awlen, 8'd15);
    chk("wvalid_before_aw", m_axi_wvalid, 1'b0);
    chk("arb_req_aw", arb_req, 1'b1);
    cycle();
    chk("awvalid_stall", m_axi_awvalid, 1'b1);
    chk("awaddr_stall", m_axi_awaddr, exp_addr);
    m_axi_awready = 1'b1;
    cycle();
    m_axi_awready = 1'b0;
    chk("awvalid_drop", m_axi_awvalid, 1'b0);
    beats = 0;
    n = 0;
    while (beats < BL && n < 200) begin
      m_axi_wready = toggle_w ? (n % 2 == 0) : 1'b1;
      frame_start  = fs_mid && (n == 3);
      #1;
      if (m_axi_wvalid) begin
        chk("wlast", m_axi_wlast, beats == BL - 1);
        if (m_axi_wready) begin
          chk("rd_req", wfifo_rd_req, 1'b1);
          chk("wdata", m_axi_wdata, word(exp_idx));
          exp_idx++;
          beats++;
        end else begin
          chk("rd_req_stall", wfifo_rd_req, 1'b0);
        end
      end
      cycle();
      n++;
    end
    m_axi_wready = 1'b0;
    frame_start  = 1'b0;
    chk("beats_done", beats, BL);
    chk("pop_count", rd_idx, exp_idx);
    chk("wvalid_in_b", m_axi_wvalid, 1'b0);
    chk("bready", m_axi_bready, 1'b1);
    chk("arb_done_early", arb_done, 1'b0);
    cycle();
    chk("arb_req_b", arb_req, 1'b1);
    chk("frame_done_early", frame_done, 1'b0);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    cycle();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    if (resp != 2'b00) err_exp = 1'b1;
    chk("arb_done", arb_done, 1'b1);
    chk("arb_req_drop", arb_req, 1'b0);
    chk("bready_drop", m_axi_bready, 1'b0);
    chk("frame_done", frame_done, exp_fdone);
    chk("wr_err", wr_err, err_exp);
    cycle();
    chk("arb_done_pulse", arb_done, 1'b0);
    chk("frame_done_pulse", frame_done, 1'b0);
  endtask

  typedef struct {
    int unsigned level;
    bit          grant;
    bit          exp_req;
    bit          exp_awv;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0,   1'b1, 1'b0, 1'b0};
    vecs[1] = '{15,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{16,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{16,  1'b1, 1'b1, 1'b1};
    vecs[4] = '{17,  1'b1, 1'b1, 1'b1};
    vecs[5] = '{300, 1'b0, 1'b1, 1'b0};

    do_reset();
    chk("rst_arb_req", arb_req, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_wlast", m_axi_wlast, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_arb_done", arb_done, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_rd_req", wfifo_rd_req, 1'b0);
    chk("rst_awaddr", m_axi_awaddr, BASE);
    chk("awsize", m_axi_awsize, 3'b101);
    chk("awburst", m_axi_awburst, 2'b01);
    chk("wstrb", m_axi_wstrb, 32'hFFFF_FFFF);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      wr_idx    = vecs[i].level;
      arb_grant = vecs[i].grant;
      repeat (3) cycle();
      chk($sformatf("tbl%0d_arb_req", i), arb_req, vecs[i].exp_req);
      chk($sformatf("tbl%0d_awvalid", i), m_axi_awvalid, vecs[i].exp_awv);
      chk($sformatf("tbl%0d_awaddr", i), m_axi_awaddr, BASE);
    end

    do_reset();
    burst(BASE,          2'b00, 1'b0, 1'b0, 1'b0);
    burst(BASE + BBYTES, 2'b00, 1'b1, 1'b1, 1'b0);
    burst(BASE,          2'b00, 1'b0, 1'b0, 1'b0);
    burst(BASE + BBYTES, 2'b00, 1'b0, 1'b0, 1'b1);
    burst(BASE,          2'b10, 1'b0, 1'b0, 1'b0);
    burst(BASE + BBYTES, 2'b00, 1'b0, 1'b1, 1'b0);
    burst(BASE,          2'b00, 1'b1, 1'b0, 1'b0);

    chk("idle_addr_before_fs", m_axi_awaddr, BASE + BBYTES);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("idle_fs_addr", m_axi_awaddr, BASE);
    burst(BASE, 2'b00, 1'b0, 1'b0, 1'b0);

    // Abort a burst at BASE+512 with reset while beat 5 is presented
    wr_idx    = wr_idx + BL;
    arb_grant = 1'b1;
    begin
      int unsigned n;
      n = 0;
      while (!m_axi_awvalid && n < 50) begin
        cycle();
        n++;
      end
    end
    chk("abort_aw_seen", m_axi_awvalid, 1'b1);
    chk("abort_awaddr", m_axi_awaddr, BASE + BBYTES);
    m_axi_awready = 1'b1;
    cycle();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b1;
    repeat (4) cycle();
    chk("abort_wvalid_pre", m_axi_wvalid, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("abort_arb_req", arb_req, 1'b0);
    chk("abort_wvalid", m_axi_wvalid, 1'b0);
    chk("abort_wlast", m_axi_wlast, 1'b0);
    chk("abort_awvalid", m_axi_awvalid, 1'b0);
    chk("abort_bready", m_axi_bready, 1'b0);
    chk("abort_rd_req", wfifo_rd_req, 1'b0);
    chk("abort_wr_err", wr_err, 1'b0);
    chk("abort_awaddr_rst", m_axi_awaddr, BASE);
    do_reset();
    burst(BASE, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
